branch_ctrl: RTL and testbench

Program-flow controller sitting between instruction decode and the 8-bit program counter. Each cycle it evaluates the decoded flow opcode, zero flag and current PC, then drives the counter's jump-enable/jump-address pair. It owns a small return-address stack for CALL/RET and a RUN/HALTED/FAULT state machine that can freeze the PC.

---
 rtl/ctrl_pkg.sv | 22 ++
 rtl/ret_stack.sv | 48 ++++
 rtl/branch_ctrl.sv | 149 ++++++++++++++
 tb/tb_branch_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the program-flow controller: opcodes, FSM states and the address width.
package ctrl_pkg;

  localparam int unsigned AW = 8;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_JZ   = 3'd2;
  localparam logic [2:0] OP_JNZ  = 3'd3;
  localparam logic [2:0] OP_CALL = 3'd4;
  localparam logic [2:0] OP_RET  = 3'd5;
  localparam logic [2:0] OP_HALT = 3'd6;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  typedef logic [AW-1:0] addr_t;

endpackage

// File: rtl/ret_stack.sv
// DEPTH x AW LIFO of return addresses; count is registered, top/full/empty decode from it.
module ret_stack
  import ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SPW   = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic           pop,
  input  logic [AW-1:0]  din,
  output logic [AW-1:0]  top_c,
  output logic [SPW-1:0] count,
  output logic           full_c,
  output logic           empty_c
);

  localparam int unsigned IW = $clog2(DEPTH);

  logic [AW-1:0] mem [DEPTH];
  logic [IW-1:0] wr_idx_c;
  logic [IW-1:0] rd_idx_c;

  assign wr_idx_c = IW'(count);
  assign rd_idx_c = IW'(count - SPW'(1));
  assign full_c   = (count == SPW'(DEPTH));
  assign empty_c  = (count == '0);
  assign top_c    = mem[rd_idx_c];

  // Entries are deliberately left uncleared by reset; only the occupancy resets.
  always_ff @(posedge clk) begin
    if (push && !full_c) begin
      mem[wr_idx_c] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (push && !full_c) begin
      count <= count + SPW'(1);
    end else if (pop && !empty_c) begin
      count <= count - SPW'(1);
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// Per-cycle flow decision driving the PC's jump-enable/jump-address pair.
// BRANCH_CTRL_RETSTACK_EN builds the CALL/RET return stack and its over/underflow FAULT.
module branch_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SPW   = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2:0]     op,
  input  logic [AW-1:0]  target,
  input  logic           zero,
  input  logic [AW-1:0]  pc,
  input  logic           resume,
  output logic           jmp_en,
  output logic [AW-1:0]  jmp_addr,
  output logic           halted,
  output logic           fault,
  output logic [SPW-1:0] sp
);

  state_t state;
  state_t state_nxt;
  logic   jmp_en_nxt;
  addr_t  jmp_addr_nxt;
  addr_t  halt_pc;
  addr_t  halt_pc_nxt;

`ifdef BRANCH_CTRL_RETSTACK_EN
  logic  push_c;
  logic  pop_c;
  addr_t top_c;
  logic  full_c;
  logic  empty_c;

  ret_stack #(
    .DEPTH (DEPTH),
    .SPW   (SPW)
  ) u_ret_stack (
    .clk     (clk),
    .rst     (rst),
    .push    (push_c),
    .pop     (pop_c),
    .din     (pc + AW'(1)),
    .top_c   (top_c),
    .count   (sp),
    .full_c  (full_c),
    .empty_c (empty_c)
  );
`else
  assign sp = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      jmp_en   <= 1'b0;
      jmp_addr <= '0;
      halt_pc  <= '0;
      halted   <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state    <= state_nxt;
      jmp_en   <= jmp_en_nxt;
      jmp_addr <= jmp_addr_nxt;
      halt_pc  <= halt_pc_nxt;
      halted   <= (state_nxt == ST_HALTED);
      fault    <= (state_nxt == ST_FAULT);
    end
  end

  // Next state and next registered outputs; jmp_addr holds when not loading.
  always_comb begin
    state_nxt    = state;
    jmp_en_nxt   = jmp_en;
    jmp_addr_nxt = jmp_addr;
    halt_pc_nxt  = halt_pc;
`ifdef BRANCH_CTRL_RETSTACK_EN
    push_c       = 1'b0;
    pop_c        = 1'b0;
`endif
    case (state)
      ST_RUN: begin
        jmp_en_nxt = 1'b0;
        case (op)
          OP_JMP: begin
            jmp_en_nxt   = 1'b1;
            jmp_addr_nxt = target;
          end
          OP_JZ: begin
            jmp_en_nxt   = zero;
            jmp_addr_nxt = target;
          end
          OP_JNZ: begin
            jmp_en_nxt   = !zero;
            jmp_addr_nxt = target;
          end
          OP_CALL: begin
            jmp_en_nxt   = 1'b1;
            jmp_addr_nxt = target;
`ifdef BRANCH_CTRL_RETSTACK_EN
            if (full_c) begin
              state_nxt    = ST_FAULT;
              jmp_addr_nxt = pc;
            end else begin
              push_c = 1'b1;
            end
`endif
          end
          OP_RET: begin
`ifdef BRANCH_CTRL_RETSTACK_EN
            jmp_en_nxt = 1'b1;
            if (empty_c) begin
              state_nxt    = ST_FAULT;
              jmp_addr_nxt = pc;
            end else begin
              pop_c        = 1'b1;
              jmp_addr_nxt = top_c;
            end
`endif
          end
          OP_HALT: begin
            state_nxt    = ST_HALTED;
            halt_pc_nxt  = pc;
            jmp_en_nxt   = 1'b1;
            jmp_addr_nxt = pc;
          end
          default: ;
        endcase
      end
      ST_HALTED: begin
        jmp_en_nxt   = 1'b1;
        jmp_addr_nxt = halt_pc;
        if (resume) begin
          state_nxt  = ST_RUN;
          jmp_en_nxt = 1'b0;
        end
      end
      ST_FAULT: begin
        jmp_en_nxt = 1'b1;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Randomized bench for branch_ctrl with a queue-based reference model and a PC driven from the DUT outputs.
module tb_branch_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned SPW   = $clog2(DEPTH + 1);

  localparam logic [2:0] NOP = 3'd0, JMP = 3'd1, JZ = 3'd2, JNZ = 3'd3;
  localparam logic [2:0] CALL = 3'd4, RET = 3'd5, HALT = 3'd6;

`ifdef BRANCH_CTRL_RETSTACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [2:0]     op;
  logic [7:0]     target;
  logic           zero;
  logic [7:0]     pc;
  logic           resume;
  logic           jmp_en;
  logic [7:0]     jmp_addr;
  logic           halted;
  logic           fault;
  logic [SPW-1:0] sp;

  int total = 0;
  int bad   = 0;

  logic       m_en, m_halt, m_fault;
  logic [7:0] m_addr, m_hpc;
  logic [7:0] stk[$];

  branch_ctrl #(.DEPTH(DEPTH), .SPW(SPW)) dut (
    .clk      (clk),
    .rst      (rst),
    .op       (op),
    .target   (target),
    .zero     (zero),
    .pc       (pc),
    .resume   (resume),
    .jmp_en   (jmp_en),
    .jmp_addr (jmp_addr),
    .halted   (halted),
    .fault    (fault),
    .sp       (sp)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_en = 1'b0; m_addr = 8'h00; m_halt = 1'b0; m_fault = 1'b0; m_hpc = 8'h00;
    stk.delete();
  endfunction

  function automatic void model_step(input logic [2:0] o, input logic [7:0] t, input logic z,
                                     input logic [7:0] p, input logic r);
    logic [7:0] ra;
    ra = p + 8'd1;
    if (m_fault) begin
      m_en = 1'b1;
    end else if (m_halt) begin
      m_en = 1'b1; m_addr = m_hpc;
      if (r) begin m_halt = 1'b0; m_en = 1'b0; end
    end else begin
      m_en = 1'b0;
      case (o)
        JMP: begin m_en = 1'b1; m_addr = t; end
        JZ:  begin m_en = z;    m_addr = t; end
        JNZ: begin m_en = !z;   m_addr = t; end
        CALL: begin
          m_en = 1'b1; m_addr = t;
          if (STK) begin
            if (stk.size() == DEPTH) begin m_fault = 1'b1; m_addr = p; end
            else stk.push_back(ra);
          end
        end
        RET: begin
          if (STK) begin
            m_en = 1'b1;
            if (stk.size() == 0) begin m_fault = 1'b1; m_addr = p; end
            else m_addr = stk.pop_back();
          end
        end
        HALT: begin m_halt = 1'b1; m_hpc = p; m_en = 1'b1; m_addr = p; end
        default: ;
      endcase
    end
  endfunction

  // One decision cycle; the PC follows the DUT's jump pair like the real counter would.
  task automatic cyc(input logic [2:0] o, input logic [7:0] t, input logic z, input logic r,
                     input logic rs);
    op = o; target = t; zero = z; resume = r; rst = rs;
    if (rs) model_reset();
    else model_step(o, t, z, pc, r);
    @(posedge clk); #1;
    if (rs) pc = 8'h00;
    else pc = jmp_en ? jmp_addr : pc + 8'd1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    cyc(3'($urandom), 8'($urandom), 1'b1, 1'b1, 1'b1);
    cyc(HALT, 8'($urandom), 1'b0, 1'b0, 1'b1);
    total++;
    if ({jmp_en, jmp_addr, halted, fault, sp} !== {1'b0, 8'h00, 1'b0, 1'b0, SPW'(0)}) begin
      bad++;
      $display("FAIL reset: got en=%b addr=%h halted=%b fault=%b sp=%0d, want all zero",
               jmp_en, jmp_addr, halted, fault, sp);
    end
  endtask

  task automatic test_nop();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (pc !== 8'(i)) begin
        bad++; $display("FAIL nop_pc: got %h want %h", pc, 8'(i));
      end
      cyc(NOP, 8'($urandom), 1'($urandom), 1'b0, 1'b0);
      total++;
      if (jmp_en !== 1'b0 || sp !== SPW'(0)) begin
        bad++; $display("FAIL nop_out: got en=%b sp=%0d want en=0 sp=0", jmp_en, sp);
      end
    end
  endtask

  task automatic test_cond();
    cyc(JZ, 8'h40, 1'b1, 1'b0, 1'b0);
    total++;
    if (jmp_en !== 1'b1 || jmp_addr !== 8'h40) begin
      bad++; $display("FAIL jz_taken: got en=%b addr=%h want en=1 addr=40", jmp_en, jmp_addr);
    end
    cyc(JNZ, 8'h50, 1'b1, 1'b0, 1'b0);
    total++;
    if (jmp_en !== 1'b0) begin
      bad++; $display("FAIL jnz_not_taken: got en=%b want 0", jmp_en);
    end
    for (int i = 0; i < 24; i++) begin
      logic [2:0] o;
      o = 3'($urandom_range(0, 3));
      if (o == 3'd0) o = 3'd7;
      cyc(o, 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      total++;
      if (jmp_en !== m_en || (m_en && jmp_addr !== m_addr)) begin
        bad++; $display("FAIL cond_rand: op=%0d got en=%b addr=%h want en=%b addr=%h",
                        o, jmp_en, jmp_addr, m_en, m_addr);
      end
    end
  endtask

  task automatic test_call_ret();
    logic [2:0] ops [5] = '{CALL, NOP, CALL, RET, RET};
    logic [7:0] tgs [5] = '{8'h20, 8'h00, 8'h30, 8'h00, 8'h00};
    logic [7:0] eas [5] = '{8'h20, 8'h00, 8'h30, 8'h22, 8'h06};
    logic       ees [5];
    logic [SPW-1:0] ess [5];
    if (STK) begin
      ees = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      ess = '{SPW'(1), SPW'(1), SPW'(2), SPW'(1), SPW'(0)};
    end else begin
      ees = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      ess = '{SPW'(0), SPW'(0), SPW'(0), SPW'(0), SPW'(0)};
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(JMP, 8'h05, 1'b0, 1'b0, 1'b0);
    total++;
    if (pc !== 8'h05) begin bad++; $display("FAIL call_setup_pc: got %h want 05", pc); end
    for (int i = 0; i < 5; i++) begin
      cyc(ops[i], tgs[i], 1'b0, 1'b0, 1'b0);
      total++;
      if (jmp_en !== ees[i] || sp !== ess[i] || (ees[i] && jmp_addr !== eas[i])) begin
        bad++; $display("FAIL call_ret step %0d: got en=%b addr=%h sp=%0d want en=%b addr=%h sp=%0d",
                        i, jmp_en, jmp_addr, sp, ees[i], eas[i], ess[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] fpc;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    fpc = 8'h00;
    for (int i = 0; i <= DEPTH; i++) begin
      fpc = pc;
      cyc(CALL, 8'($urandom), 1'b0, 1'b0, 1'b0);
    end
    total++;
    if (fault !== STK || sp !== SPW'(STK ? DEPTH : 0)) begin
      bad++; $display("FAIL overflow: got fault=%b sp=%0d want fault=%b sp=%0d",
                      fault, sp, STK, STK ? DEPTH : 0);
    end
    for (int i = 0; i < 4 && STK; i++) begin
      cyc(3'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      total++;
      if (fault !== 1'b1 || pc !== fpc || sp !== SPW'(DEPTH)) begin
        bad++; $display("FAIL fault_hold: got fault=%b pc=%h sp=%0d want fault=1 pc=%h sp=%0d",
                        fault, pc, sp, fpc, DEPTH);
      end
    end
    cyc(RET, 8'h00, 1'b0, 1'b1, 1'b1);
    total++;
    if (fault !== 1'b0 || sp !== SPW'(0) || jmp_en !== 1'b0) begin
      bad++; $display("FAIL fault_reset: got fault=%b sp=%0d en=%b want 0 0 0", fault, sp, jmp_en);
    end
    cyc(RET, 8'h00, 1'b0, 1'b0, 1'b0);
    total++;
    if (fault !== STK || jmp_en !== STK) begin
      bad++; $display("FAIL underflow: got fault=%b en=%b want fault=%b en=%b", fault, jmp_en, STK, STK);
    end
    cyc(NOP, 8'h00, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_halt();
    cyc(JMP, 8'h10, 1'b0, 1'b1, 1'b0);
    cyc(HALT, 8'h77, 1'b0, 1'b0, 1'b0);
    total++;
    if (halted !== 1'b1 || pc !== 8'h10) begin
      bad++; $display("FAIL halt_enter: got halted=%b pc=%h want 1 10", halted, pc);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(3'($urandom), 8'($urandom), 1'($urandom), 1'b0, 1'b0);
      total++;
      if (halted !== 1'b1 || pc !== 8'h10 || fault !== 1'b0) begin
        bad++; $display("FAIL halt_hold %0d: got halted=%b pc=%h fault=%b want 1 10 0",
                        i, halted, pc, fault);
      end
    end
    cyc(RET, 8'h00, 1'b0, 1'b1, 1'b0);
    total++;
    if (halted !== 1'b0 || pc !== 8'h11) begin
      bad++; $display("FAIL resume: got halted=%b pc=%h want 0 11", halted, pc);
    end
    cyc(NOP, 8'h00, 1'b0, 1'b1, 1'b0);
    total++;
    if (halted !== 1'b0 || jmp_en !== 1'b0 || pc !== 8'h12) begin
      bad++; $display("FAIL resume_in_run: got halted=%b en=%b pc=%h want 0 0 12", halted, jmp_en, pc);
    end
    cyc(HALT, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(HALT, 8'h00, 1'b0, 1'b0, 1'b1);
    total++;
    if (halted !== 1'b0 || jmp_en !== 1'b0) begin
      bad++; $display("FAIL halt_reset: got halted=%b en=%b want 0 0", halted, jmp_en);
    end
  endtask

  task automatic test_wrap();
    cyc(JMP, 8'hFF, 1'b0, 1'b0, 1'b0);
    cyc(CALL, 8'h40, 1'b0, 1'b0, 1'b0);
    cyc(RET, 8'h00, 1'b0, 1'b0, 1'b0);
    total++;
    if (STK ? (jmp_en !== 1'b1 || jmp_addr !== 8'h00 || pc !== 8'h00)
            : (jmp_en !== 1'b0 || pc !== 8'h41)) begin
      bad++; $display("FAIL wrap: got en=%b addr=%h pc=%h want return to %h",
                      jmp_en, jmp_addr, pc, STK ? 8'h00 : 8'h41);
    end
  endtask

  task automatic test_random();
    cyc(NOP, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      logic [2:0] o;
      logic rs;
      o  = 3'($urandom_range(0, 7));
      rs = ($urandom_range(0, 39) == 0);
      cyc(o, 8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), rs);
      total++;
      if ({jmp_en, halted, fault, sp} !== {m_en, m_halt, m_fault, SPW'(stk.size())} ||
          (m_en && jmp_addr !== m_addr)) begin
        bad++; $display("FAIL random %0d op=%0d: got en=%b addr=%h h=%b f=%b sp=%0d want en=%b addr=%h h=%b f=%b sp=%0d",
                        i, o, jmp_en, jmp_addr, halted, fault, sp,
                        m_en, m_addr, m_halt, m_fault, stk.size());
      end
    end
  endtask

  initial begin
    rst = 1'b1; op = NOP; target = 8'h00; zero = 1'b0; resume = 1'b0; pc = 8'h00;
    model_reset();
    test_reset();
    test_nop();
    test_cond();
    test_call_ret();
    test_overflow();
    test_halt();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
